// File: rtl/stopwatch_ctrl.sv
// Stopwatch controller: synchronises the 100 Hz tick and two debounced buttons,
// runs the run/lap/pause FSM and keeps a saturating BCD mm:ss.cc count plus a lap capture.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | count cleared, waiting for start
// RUN    | counting, display shows live count
// LAP    | counting, display frozen on lap_reg
// PAUSE  | count held; if overflow is set only lap/clear leaves
module stopwatch_ctrl #(
    parameter int MAX_MIN     = 59,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk_50MHz,
    input  logic       rst_n,
    input  logic       tick_100Hz,
    input  logic       btn_ss,
    input  logic       btn_lc,
    output logic [3:0] disp_min_t,
    output logic [3:0] disp_min_u,
    output logic [3:0] disp_sec_t,
    output logic [3:0] disp_sec_u,
    output logic [3:0] disp_cs_t,
    output logic [3:0] disp_cs_u,
    output logic       running,
    output logic       frozen,
    output logic       overflow
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_LAP   = 2'd2;
    localparam logic [1:0] S_PAUSE = 2'd3;

    localparam logic [3:0] MAX_T = 4'(MAX_MIN / 10);
    localparam logic [3:0] MAX_U = 4'(MAX_MIN % 10);
    localparam logic [23:0] COUNT_MAX = {MAX_T, MAX_U, 4'd5, 4'd9, 4'd9, 4'd9};

    logic [SYNC_STAGES-1:0] sync_tick, sync_ss, sync_lc;
    logic [2:0]             prev;
    logic                   tick_p, ss_p, lc_p;

    logic [1:0]  state;
    logic [23:0] count, count_inc, lap_reg, disp;
    logic        count_en, at_max;

    always_ff @(posedge clk_50MHz or negedge rst_n) begin
        if (!rst_n) begin
            sync_tick <= '0;
            sync_ss   <= '0;
            sync_lc   <= '0;
            prev      <= '0;
        end else begin
            sync_tick <= {sync_tick[SYNC_STAGES-2:0], tick_100Hz};
            sync_ss   <= {sync_ss[SYNC_STAGES-2:0], btn_ss};
            sync_lc   <= {sync_lc[SYNC_STAGES-2:0], btn_lc};
            prev      <= {sync_tick[SYNC_STAGES-1], sync_ss[SYNC_STAGES-1], sync_lc[SYNC_STAGES-1]};
        end
    end

    assign tick_p = sync_tick[SYNC_STAGES-1] & ~prev[2];
    assign ss_p   = sync_ss[SYNC_STAGES-1]   & ~prev[1];
    assign lc_p   = sync_lc[SYNC_STAGES-1]   & ~prev[0];

    assign count_en = tick_p && (state == S_RUN || state == S_LAP);
    assign at_max   = (count == COUNT_MAX);

    // BCD ripple: each digit wraps only when all lower digits wrap
    always_comb begin
        count_inc = count;
        if (count[3:0] != 4'd9) begin
            count_inc[3:0] = count[3:0] + 4'd1;
        end else begin
            count_inc[3:0] = 4'd0;
            if (count[7:4] != 4'd9) begin
                count_inc[7:4] = count[7:4] + 4'd1;
            end else begin
                count_inc[7:4] = 4'd0;
                if (count[11:8] != 4'd9) begin
                    count_inc[11:8] = count[11:8] + 4'd1;
                end else begin
                    count_inc[11:8] = 4'd0;
                    if (count[15:12] != 4'd5) begin
                        count_inc[15:12] = count[15:12] + 4'd1;
                    end else begin
                        count_inc[15:12] = 4'd0;
                        if (count[19:16] != 4'd9) begin
                            count_inc[19:16] = count[19:16] + 4'd1;
                        end else begin
                            count_inc[19:16] = 4'd0;
                            count_inc[23:20] = count[23:20] + 4'd1;
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_50MHz or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            count    <= '0;
            lap_reg  <= '0;
            overflow <= 1'b0;
        end else if (count_en && at_max) begin
            // saturation overrides any button action in the same cycle
            overflow <= 1'b1;
            state    <= S_PAUSE;
        end else begin
            if (count_en) count <= count_inc;
            case (state)
                S_IDLE: begin
                    if (ss_p) state <= S_RUN;
                end
                S_RUN: begin
                    if (ss_p) begin
                        state <= S_PAUSE;
                    end else if (lc_p) begin
                        state   <= S_LAP;
                        lap_reg <= count;
                    end
                end
                S_LAP: begin
                    if (ss_p)      state <= S_PAUSE;
                    else if (lc_p) state <= S_RUN;
                end
                default: begin
                    if (ss_p && !overflow) begin
                        state <= S_RUN;
                    end else if (lc_p) begin
                        state    <= S_IDLE;
                        count    <= '0;
                        lap_reg  <= '0;
                        overflow <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign running = (state == S_RUN) || (state == S_LAP);
    assign frozen  = (state == S_LAP);
    assign disp    = frozen ? lap_reg : count;

    assign disp_min_t = disp[23:20];
    assign disp_min_u = disp[19:16];
    assign disp_sec_t = disp[15:12];
    assign disp_sec_u = disp[11:8];
    assign disp_cs_t  = disp[7:4];
    assign disp_cs_u  = disp[3:0];

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Scoreboard bench for stopwatch_ctrl: expected display/status pushed with each stimulus
// step, popped and compared once the synchroniser latency has elapsed.
module tb_stopwatch_ctrl;

    localparam int SYNC = 2;
    localparam int SETTLE = SYNC + 3;

    typedef struct {
        string      tag;
        logic [23:0] disp;
        logic       run;
        logic       frz;
        logic       ovf;
    } exp_t;

    logic clk_50MHz = 1'b0;
    logic rst_n = 1'b0;
    logic tick_100Hz = 1'b0;
    logic btn_ss = 1'b0;
    logic btn_lc = 1'b0;
    logic [3:0] disp_min_t, disp_min_u, disp_sec_t, disp_sec_u, disp_cs_t, disp_cs_u;
    logic running, frozen, overflow;

    int n_tests = 0;
    int n_fail = 0;
    exp_t sb[$];

    stopwatch_ctrl #(.MAX_MIN(1), .SYNC_STAGES(SYNC)) dut (
        .clk_50MHz (clk_50MHz),
        .rst_n     (rst_n),
        .tick_100Hz(tick_100Hz),
        .btn_ss    (btn_ss),
        .btn_lc    (btn_lc),
        .disp_min_t(disp_min_t),
        .disp_min_u(disp_min_u),
        .disp_sec_t(disp_sec_t),
        .disp_sec_u(disp_sec_u),
        .disp_cs_t (disp_cs_t),
        .disp_cs_u (disp_cs_u),
        .running   (running),
        .frozen    (frozen),
        .overflow  (overflow)
    );

    always #10 clk_50MHz = ~clk_50MHz;

    task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [23:0] to_bcd(input int t_cs);
        int m, s, c;
        m = t_cs / 6000;
        s = (t_cs / 100) % 60;
        c = t_cs % 100;
        return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10), 4'(c / 10), 4'(c % 10)};
    endfunction

    task automatic sb_push(input string tag, input int t_cs, input logic run, input logic frz,
                           input logic ovf);
        exp_t e;
        e.tag  = tag;
        e.disp = to_bcd(t_cs);
        e.run  = run;
        e.frz  = frz;
        e.ovf  = ovf;
        sb.push_back(e);
    endtask

    task automatic sb_drain(input int wait_cyc);
        exp_t e;
        logic [23:0] d;
        repeat (wait_cyc) @(negedge clk_50MHz);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            d = {disp_min_t, disp_min_u, disp_sec_t, disp_sec_u, disp_cs_t, disp_cs_u};
            chk_val({e.tag, ".disp"}, 32'(d), 32'(e.disp));
            chk_val({e.tag, ".running"}, 32'(running), 32'(e.run));
            chk_val({e.tag, ".frozen"}, 32'(frozen), 32'(e.frz));
            chk_val({e.tag, ".overflow"}, 32'(overflow), 32'(e.ovf));
        end
    endtask

    // one tick = one clock high, one clock low (compressed to keep long runs short)
    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) begin
            tick_100Hz = 1'b1;
            @(negedge clk_50MHz);
            tick_100Hz = 1'b0;
            @(negedge clk_50MHz);
        end
    endtask

    task automatic press(input logic ss, input logic lc);
        btn_ss = ss;
        btn_lc = lc;
        repeat (5) @(negedge clk_50MHz);
        btn_ss = 1'b0;
        btn_lc = 1'b0;
        repeat (4) @(negedge clk_50MHz);
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not complete, want finish before 5 ms");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset asserted from time zero: outputs already cleared
        #5;
        sb_push("reset", 0, 1'b0, 1'b0, 1'b0);
        sb_drain(0);
        repeat (3) @(negedge clk_50MHz);
        rst_n = 1'b1;
        repeat (2) @(negedge clk_50MHz);

        // 1: idle ignores ticks
        tick_n(50);
        sb_push("t1_idle", 0, 1'b0, 1'b0, 1'b0);
        sb_drain(SETTLE);

        // 2: start, latency of first increment, then 1234 ticks total
        press(1'b1, 1'b0);
        sb_push("t2_run", 0, 1'b1, 1'b0, 1'b0);
        sb_drain(0);
        tick_100Hz = 1'b1;
        repeat (SYNC) @(negedge clk_50MHz);
        sb_push("t2_lat_before", 0, 1'b1, 1'b0, 1'b0);
        sb_drain(0);
        @(negedge clk_50MHz);
        sb_push("t2_lat_after", 1, 1'b1, 1'b0, 1'b0);
        sb_drain(0);
        tick_100Hz = 1'b0;
        @(negedge clk_50MHz);
        tick_n(1233);
        sb_push("t2_1234", 1234, 1'b1, 1'b0, 1'b0);
        sb_drain(SETTLE);

        // 3: pause, clear, restart to 00:05.00, lap freeze and release
        press(1'b1, 1'b0);
        sb_push("t3_pause", 1234, 1'b0, 1'b0, 1'b0);
        sb_drain(0);
        press(1'b0, 1'b1);
        sb_push("t3_clear", 0, 1'b0, 1'b0, 1'b0);
        sb_drain(0);
        press(1'b1, 1'b0);
        tick_n(500);
        sb_push("t3_500", 500, 1'b1, 1'b0, 1'b0);
        sb_drain(SETTLE);
        press(1'b0, 1'b1);
        tick_n(300);
        sb_push("t3_lap_frozen", 500, 1'b1, 1'b1, 1'b0);
        sb_drain(SETTLE);
        press(1'b0, 1'b1);
        sb_push("t3_lap_release", 800, 1'b1, 1'b0, 1'b0);
        sb_drain(0);

        // 4: simultaneous ss and lc in RUN -> PAUSE, then clear
        press(1'b1, 1'b1);
        sb_push("t4_both", 800, 1'b0, 1'b0, 1'b0);
        sb_drain(0);
        tick_n(20);
        sb_push("t4_hold", 800, 1'b0, 1'b0, 1'b0);
        sb_drain(SETTLE);
        press(1'b0, 1'b1);
        sb_push("t4_idle", 0, 1'b0, 1'b0, 1'b0);
        sb_drain(0);

        // 5: run to 01:59.99 (MAX_MIN=1), saturate, ss ignored, lc clears
        press(1'b1, 1'b0);
        tick_n(11999);
        sb_push("t5_max", 11999, 1'b1, 1'b0, 1'b0);
        sb_drain(SETTLE);
        tick_n(1);
        sb_push("t5_ovf", 11999, 1'b0, 1'b0, 1'b1);
        sb_drain(SETTLE);
        press(1'b1, 1'b0);
        tick_n(5);
        sb_push("t5_ss_ignored", 11999, 1'b0, 1'b0, 1'b1);
        sb_drain(SETTLE);
        press(1'b0, 1'b1);
        sb_push("t5_clear", 0, 1'b0, 1'b0, 1'b0);
        sb_drain(0);

        // 6: async reset mid-run at 00:30.07
        press(1'b1, 1'b0);
        tick_n(3007);
        sb_push("t6_3007", 3007, 1'b1, 1'b0, 1'b0);
        sb_drain(SETTLE);
        @(posedge clk_50MHz);
        #3;
        rst_n = 1'b0;
        #1;
        sb_push("t6_async_rst", 0, 1'b0, 1'b0, 1'b0);
        sb_drain(0);
        @(negedge clk_50MHz);
        rst_n = 1'b1;
        @(negedge clk_50MHz);
        tick_n(10);
        sb_push("t6_after_rst", 0, 1'b0, 1'b0, 1'b0);
        sb_drain(SETTLE);
        press(1'b1, 1'b0);
        tick_n(5);
        sb_push("t6_restart", 5, 1'b1, 1'b0, 1'b0);
        sb_drain(SETTLE);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
